// File: rtl/mc_pkg.sv
// Shared definitions for the Monte Carlo host driver: core mode encodings,
// run geometry, data width and the host sequencer state type.
package mc_pkg;

    localparam int DW  = 12;
    localparam int DAY = 8;
    localparam int N   = 256;

    localparam logic [1:0] DUT_IDLE  = 2'd0;
    localparam logic [1:0] DUT_PARAM = 2'd1;
    localparam logic [1:0] DUT_GEN   = 2'd2;
    localparam logic [1:0] DUT_PRICE = 2'd3;

    typedef enum logic [2:0] {
        H_IDLE,
        H_PARAM,
        H_GEN,
        H_PRICE,
        H_FINISH
    } host_state_t;

    // FINISH deliberately maps to the core's IDLE mode.
    function automatic logic [1:0] dut_mode(host_state_t s);
        case (s)
            H_PARAM: return DUT_PARAM;
            H_GEN:   return DUT_GEN;
            H_PRICE: return DUT_PRICE;
            default: return DUT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mc_host_driver_if.sv
// Host <-> pricing-core link: mode/data toward the core, valid/data/resend back.
// master = host driver side, slave = pricing core side.
interface mc_host_driver_if;
    import mc_pkg::*;

    logic          dut_valid;
    logic [DW-1:0] dut_out;
    logic          dut_resend;
    logic [1:0]    dut_state;
    logic [DW-1:0] dut_in;

    modport master (
        input  dut_valid, dut_out, dut_resend,
        output dut_state, dut_in
    );

    modport slave (
        output dut_valid, dut_out, dut_resend,
        input  dut_state, dut_in
    );

endinterface

// File: rtl/mc_path_buffer.sv
// Single-port DEPTH x DW path-sample buffer with synchronous read.
// Writes (capture) and reads (replay) never happen in the same phase.
module mc_path_buffer
    import mc_pkg::*;
#(
    parameter int DEPTH = N * DAY,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; clearing a RAM needs a sweep, and
    // every word is rewritten by the capture phase before it is ever read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mc_host_driver.sv
// Host-side sequencer for the Monte Carlo pricing core: parameter load, path
// capture, cyclic replay with resend, price latch. Optional watchdog: HOST_TIMEOUT_EN.
module mc_host_driver
    import mc_pkg::*;
#(
    parameter int DEPTH = N * DAY,
    parameter int AW    = $clog2(DEPTH)
`ifdef HOST_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 8192
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DW-1:0]    w_cfg,
    input  logic [DW-1:0]    q_cfg,
    input  logic [DW-1:0]    s_cfg,
    input  logic [DW-1:0]    k_cfg,
    mc_host_driver_if.master bus,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    price,
    output logic             error
);

    host_state_t   st, st_nxt;
    logic [2:0]    cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] addr;
    logic          rd_vld;
    logic          we;
    logic          re;
    logic          last_wr;
    logic          wd_fire;
    logic [1:0]    dut_state_q;
    logic [DW-1:0] w_q, q_q, s_q, k_q;
    logic [DW-1:0] rdata;

    assign we      = (st == H_GEN) && bus.dut_valid;
    assign last_wr = we && (wr_ptr == AW'(DEPTH - 1));
    assign re      = (st == H_PRICE);
    assign addr    = (st == H_GEN) ? wr_ptr : rd_ptr;

    mc_path_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .re    (re),
        .addr  (addr),
        .wdata (bus.dut_out),
        .rdata (rdata)
    );

`ifdef HOST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    logic [WD_W-1:0] wd_cnt;

    // Fires on the cycle the idle count reaches TIMEOUT; a valid beat always wins.
    assign wd_fire = ((st == H_GEN) || (st == H_PRICE)) && !bus.dut_valid &&
                     (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if ((st_nxt != st) || bus.dut_valid) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
        end else if ((st == H_IDLE) && start) begin
            error <= 1'b0;
        end else if (wd_fire) begin
            error <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign error   = 1'b0;
`endif

    // NOTE: st_nxt is assigned before the case so every path drives it; a
    // missing default in combinational logic infers a latch.
    always_comb begin
        st_nxt = st;
        case (st)
            H_IDLE:   if (start) st_nxt = H_PARAM;
            H_PARAM:  if (cnt == 3'd4) st_nxt = H_GEN;
            H_GEN: begin
                if (last_wr)      st_nxt = H_PRICE;
                else if (wd_fire) st_nxt = H_FINISH;
            end
            H_PRICE:  if (bus.dut_valid || wd_fire) st_nxt = H_FINISH;
            H_FINISH: st_nxt = H_IDLE;
            default:  st_nxt = H_IDLE;
        endcase
    end

    // Parameter words go out on PARAM counts 1..4; count 0 is the core's mode switch.
    always_comb begin
        bus.dut_in = '0;
        case (st)
            H_PARAM: begin
                case (cnt)
                    3'd1:    bus.dut_in = w_q;
                    3'd2:    bus.dut_in = q_q;
                    3'd3:    bus.dut_in = s_q;
                    3'd4:    bus.dut_in = k_q;
                    default: bus.dut_in = '0;
                endcase
            end
            H_PRICE: if (rd_vld) bus.dut_in = rdata;
            default: bus.dut_in = '0;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= H_IDLE;
            dut_state_q <= DUT_IDLE;
            cnt         <= '0;
            w_q         <= '0;
            q_q         <= '0;
            s_q         <= '0;
            k_q         <= '0;
        end else begin
            st          <= st_nxt;
            dut_state_q <= dut_mode(st_nxt);
            if ((st == H_IDLE) && start) begin
                cnt <= '0;
                w_q <= w_cfg;
                q_q <= q_cfg;
                s_q <= s_cfg;
                k_q <= k_cfg;
            end else if (st == H_PARAM) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    // Capture and replay pointers; resend restarts replay unless the price arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_vld <= 1'b0;
            price  <= '0;
        end else begin
            rd_vld <= re;
            if ((st == H_IDLE) && start) begin
                wr_ptr <= '0;
            end else if (we) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (!re) begin
                rd_ptr <= '0;
            end else if (bus.dut_resend && !bus.dut_valid) begin
                rd_ptr <= '0;
            end else begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (re && bus.dut_valid) begin
                price <= bus.dut_out;
            end
        end
    end

    assign bus.dut_state = dut_state_q;
    assign busy          = (st != H_IDLE);
    assign done          = (st == H_FINISH);

endmodule

// File: tb/tb_mc_host_driver.sv
// Directed bench for mc_host_driver: the bench plays the pricing core.
// Build with HOST_TIMEOUT_EN to add the watchdog scenario (TIMEOUT=100).
module tb_mc_host_driver;
    import mc_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] w_cfg, q_cfg, s_cfg, k_cfg;
    logic          busy, done, error;
    logic [DW-1:0] price;

    int checks = 0;
    int errors = 0;

`ifdef HOST_TIMEOUT_EN
    localparam int WARMUP = 50;
`else
    localparam int WARMUP = 2001;
`endif

    typedef struct {
        logic          start;
        logic [1:0]    st;
        logic [DW-1:0] din;
    } pvec_t;

    typedef struct {
        logic          resend;
        logic [DW-1:0] din;
    } rvec_t;

    always #5 clk = ~clk;

    mc_host_driver_if bus ();

    mc_host_driver #(
`ifdef HOST_TIMEOUT_EN
        .TIMEOUT (100)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .w_cfg (w_cfg),
        .q_cfg (q_cfg),
        .s_cfg (s_cfg),
        .k_cfg (k_cfg),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .price (price),
        .error (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and walk the PARAM phase; cfg is scrambled after start to
    // prove it was sampled on the start cycle, and a stray start is ignored.
    task automatic run_param(input logic [DW-1:0] w, q, s, k);
        pvec_t pv [6];
        pv[0] = '{1'b0, DUT_PARAM, 12'h000};
        pv[1] = '{1'b0, DUT_PARAM, w};
        pv[2] = '{1'b1, DUT_PARAM, q};
        pv[3] = '{1'b0, DUT_PARAM, s};
        pv[4] = '{1'b0, DUT_PARAM, k};
        pv[5] = '{1'b0, DUT_GEN,   12'h000};
        w_cfg = w;
        q_cfg = q;
        s_cfg = s;
        k_cfg = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        w_cfg = ~w;
        q_cfg = ~q;
        s_cfg = ~s;
        k_cfg = ~k;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("param[%0d].state", i), 32'(bus.dut_state), 32'(pv[i].st));
            check($sformatf("param[%0d].din", i), 32'(bus.dut_in), 32'(pv[i].din));
            if (i < 5) begin
                start = pv[i].start;
                tick();
            end
        end
        start = 1'b0;
        check("param.busy", 32'(busy), 32'd1);
    endtask

    // Warm-up idle cycles, then nsamp samples of value i*mult; a garbage word
    // with valid low is inserted every gap_every samples.
    task automatic capture(input int warm, input int nsamp, input int gap_every, input int mult);
        bus.dut_valid = 1'b0;
        bus.dut_out   = '0;
        for (int c = 0; c < warm; c++) tick();
        check("gen.after_warmup.state", 32'(bus.dut_state), 32'(DUT_GEN));
        for (int i = 0; i < nsamp; i++) begin
            if ((gap_every > 0) && (i > 0) && (i % gap_every == 0)) begin
                bus.dut_valid = 1'b0;
                bus.dut_out   = 12'hFFF;
                tick();
            end
            if (i == 2047) begin
                check("gen.before_last.state", 32'(bus.dut_state), 32'(DUT_GEN));
            end
            bus.dut_valid = 1'b1;
            bus.dut_out   = DW'(i * mult);
            tick();
        end
        bus.dut_valid = 1'b0;
        bus.dut_out   = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        rvec_t rv [11];
        rv[0]  = '{1'b0, 12'd0};
        rv[1]  = '{1'b0, 12'd0};
        rv[2]  = '{1'b0, 12'd1};
        rv[3]  = '{1'b0, 12'd2};
        rv[4]  = '{1'b0, 12'd3};
        rv[5]  = '{1'b0, 12'd4};
        rv[6]  = '{1'b1, 12'd5};
        rv[7]  = '{1'b0, 12'd6};
        rv[8]  = '{1'b0, 12'd0};
        rv[9]  = '{1'b0, 12'd1};
        rv[10] = '{1'b0, 12'd2};

        rst_n          = 1'b0;
        start          = 1'b0;
        w_cfg          = '0;
        q_cfg          = '0;
        s_cfg          = '0;
        k_cfg          = '0;
        bus.dut_valid  = 1'b0;
        bus.dut_out    = '0;
        bus.dut_resend = 1'b0;
        tick();
        tick();
        check("reset.dut_state", 32'(bus.dut_state), 32'd0);
        check("reset.dut_in", 32'(bus.dut_in), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.price", 32'(price), 32'd0);
        check("reset.error", 32'(error), 32'd0);
        rst_n = 1'b1;
        tick();

        // Run 1: full capture with gaps, replay with resend, wrap, price.
        run_param(12'h123, 12'h045, 12'h800, 12'h7F0);
        capture(WARMUP, 2048, 500, 1);
        check("price.entry.state", 32'(bus.dut_state), 32'(DUT_PRICE));
        for (int i = 0; i < 11; i++) begin
            check($sformatf("replay[%0d].din", i), 32'(bus.dut_in), 32'(rv[i].din));
            bus.dut_resend = rv[i].resend;
            tick();
        end
        bus.dut_resend = 1'b0;
`ifndef HOST_TIMEOUT_EN
        for (int k = 3; k <= 2050; k++) begin
            check($sformatf("wrap.word%0d", k), 32'(bus.dut_in), 32'(k % 2048));
            tick();
        end
`endif
        bus.dut_valid = 1'b1;
        bus.dut_out   = 12'h3A7;
        tick();
        bus.dut_valid = 1'b0;
        bus.dut_out   = '0;
        check("run1.done", 32'(done), 32'd1);
        check("run1.price", 32'(price), 32'h3A7);
        check("run1.finish.state", 32'(bus.dut_state), 32'(DUT_IDLE));
        check("run1.finish.busy", 32'(busy), 32'd1);
        check("run1.error", 32'(error), 32'd0);
        tick();
        check("run1.done_pulse", 32'(done), 32'd0);
        check("run1.idle.busy", 32'(busy), 32'd0);
        check("run1.idle.din", 32'(bus.dut_in), 32'd0);
        check("run1.price_hold", 32'(price), 32'h3A7);

        // Run 2: asynchronous reset after 1000 captured samples.
        run_param(12'hABC, 12'h001, 12'h400, 12'h3FF);
        capture(10, 1000, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset.dut_state", 32'(bus.dut_state), 32'd0);
        check("midreset.dut_in", 32'(bus.dut_in), 32'd0);
        check("midreset.busy", 32'(busy), 32'd0);
        check("midreset.done", 32'(done), 32'd0);
        check("midreset.price", 32'(price), 32'd0);
        check("midreset.error", 32'(error), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Run 3: clean run after reset; valid and resend together.
        run_param(12'h0F0, 12'h00F, 12'hF00, 12'h555);
        capture(10, 2048, 700, 3);
        check("run3.entry.state", 32'(bus.dut_state), 32'(DUT_PRICE));
        check("run3.word_none", 32'(bus.dut_in), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("run3.word%0d", k), 32'(bus.dut_in), 32'(k * 3));
            tick();
        end
        bus.dut_valid  = 1'b1;
        bus.dut_resend = 1'b1;
        bus.dut_out    = 12'h1C4;
        tick();
        bus.dut_valid  = 1'b0;
        bus.dut_resend = 1'b0;
        bus.dut_out    = '0;
        check("run3.done", 32'(done), 32'd1);
        check("run3.price", 32'(price), 32'h1C4);
        check("run3.finish.state", 32'(bus.dut_state), 32'(DUT_IDLE));
        tick();
        check("run3.idle.busy", 32'(busy), 32'd0);
        check("run3.done_pulse", 32'(done), 32'd0);

`ifdef HOST_TIMEOUT_EN
        // Watchdog: no price in PRICE for 100 cycles forces FINISH with error.
        run_param(12'h111, 12'h222, 12'h333, 12'h444);
        capture(5, 2048, 0, 1);
        check("wd.entry.state", 32'(bus.dut_state), 32'(DUT_PRICE));
        for (int c = 0; c < 99; c++) tick();
        check("wd.done_before", 32'(done), 32'd0);
        tick();
        check("wd.done", 32'(done), 32'd1);
        check("wd.error", 32'(error), 32'd1);
        check("wd.price_kept", 32'(price), 32'h1C4);
        tick();
        check("wd.error_held", 32'(error), 32'd1);
        check("wd.idle.busy", 32'(busy), 32'd0);
        run_param(12'h001, 12'h002, 12'h003, 12'h004);
        check("wd.error_cleared", 32'(error), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_host_driver.md
# mc_host_driver

Host-side counterpart of the Monte Carlo pricing core: drives the core's 2-bit mode input and 12-bit data input, and consumes its valid/out/resend outputs. Sequences one full run: loads w, q, S, K; waits through Sobol warm-up; captures every generated path sample into an on-chip buffer; replays the buffer as pricing input, restarting on resend; latches the final price. Sits between the test/system controller and the pricing core.

## Interface
- DEPTH, 2048: buffer words; equals N·DAY (256 paths × 8 days).
- AW, 11: buffer address width, log2(DEPTH).
- TIMEOUT, 8192: watchdog limit in cycles, used only with HOST_TIMEOUT_EN.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE, ignored otherwise.
- w_cfg, q_cfg, s_cfg, k_cfg  in  12 each  parameters; sampled on the start cycle.
- dut_valid  in  1  core output valid.
- dut_out  in  12  core output data: path sample or price.
- dut_resend  in  1  core requests path replay from word 0.
- dut_state  out  2  core mode: 0 IDLE, 1 PARAM, 2 SOBOL/GEN, 3 PRICING.
- dut_in  out  12  core data input.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- price  out  12  last latched price; holds until next price.
- error  out  1  watchdog fired (HOST_TIMEOUT_EN only; tied 0 otherwise).

## Operation
- States: IDLE, PARAM, GEN, PRICE, FINISH.
- IDLE: dut_state=0, dut_in=0. On start: latch cfg, phase counter=0, go PARAM.
- PARAM: dut_state=1 for 5 cycles; dut_in = 0, w, q, S, K on counts 0..4 (count 0 is the core's IDLE→PARAM cycle). After count 4, go GEN.
- GEN: dut_state=2, dut_in=0. Each cycle with dut_valid=1: write dut_out to buffer[wr_ptr], wr_ptr++. When the write makes wr_ptr reach DEPTH (2048th sample), go PRICE. Cycles without dut_valid (Sobol warm-up, ~2001 cycles) only wait.
- PRICE: dut_state=3. rd_ptr starts at 0; one word per cycle on dut_in; rd_ptr wraps DEPTH-1→0 and continues cyclically. dut_resend=1 on a cycle sets rd_ptr=0 for the next read. dut_valid=1: latch dut_out into price, go FINISH.
- dut_valid and dut_resend in the same PRICE cycle: valid wins, no restart.
- FINISH: dut_state=0 for one cycle, done=1, then IDLE.
- start outside IDLE: ignored. Asynchronous reset mid-run: immediate return to IDLE, pointers cleared, buffer contents undefined.

## Timing
- Reset values: dut_state=0, dut_in=0, busy=0, done=0, price=0, error=0.
- State output dut_state is registered: changes the cycle after the state transition decision.
- Buffer read is synchronous: read address at cycle t gives dut_in at t+1. Entering PRICE at t0: word 0 on dut_in at t0+1, word k at t0+1+k. Resend sampled at t: word 0 on dut_in at t+2.
- Capture: zero-latency write on the dut_valid cycle; no back-pressure toward the core.
- done asserted the cycle after the dut_valid that carried the price; price updated the same edge.

## Configuration
- HOST_TIMEOUT_EN defined: a cycle counter clears on every state change and every dut_valid; reaching TIMEOUT in GEN or PRICE forces FINISH with error=1 (held until next start); price is not updated.
- Not defined: no counter; GEN/PRICE wait indefinitely; error tied 0.

## Structure
- Shared package mc_pkg: dut_state encodings (DUT_IDLE=0, DUT_PARAM=1, DUT_GEN=2, DUT_PRICE=3), DAY=8, N=256, data width 12, host FSM state enum.
- One sub-module: mc_path_buffer, single-port DEPTH×12 synchronous RAM (write and read never overlap: GEN writes, PRICE reads).

## Test plan
- Param load: start with w=0x123, q=0x045, S=0x800, K=0x7F0 -> dut_in sequence 0, 0x123, 0x045, 0x800, 0x7F0 with dut_state=1, then dut_state=2.
- Capture: 2001 idle cycles then 2048 valid samples of value i -> buffer holds 0..2047, PRICE entered after sample 2047; gaps in valid do not advance wr_ptr.
- Replay + resend: resend at word 5 -> dut_in sequence …, 4, 5, 6, 0, 1, …; no resend -> wrap 2047 then 0.
- Price: dut_valid with dut_out=0x3A7 in PRICE -> price=0x3A7, done one cycle later, dut_state=0, busy low.
- Simultaneous valid+resend: price latched, FINISH, no rd_ptr restart.
- Reset mid-GEN at sample 1000 -> all outputs at reset values; new start runs cleanly; with HOST_TIMEOUT_EN and TIMEOUT=100, no valid in PRICE -> error=1, done pulse at cycle 100.
